// File: rtl/param_key_repeater.sv
// Parameter key front end: two raw active-low pushbuttons are turned into
// debounced, mutually exclusive single-cycle inc/dec strobes with
// hold-to-repeat (first repeat after REPEAT_START_CNT, then every
// REPEAT_RATE_CNT cycles).
module param_key_repeater #(
  parameter int unsigned DEBOUNCE_CNT     = 1_000_000,
  parameter int unsigned REPEAT_START_CNT = 15_000_000,
  parameter int unsigned REPEAT_RATE_CNT  = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic key_inc_n,
  input  logic key_dec_n,
  output logic inc_stb,
  output logic dec_stb,
  output logic busy
);

  // Counter widths; clamped to one bit so a parameter of 1 still elaborates.
  localparam int unsigned DbW    = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int unsigned RepMax = (REPEAT_START_CNT > REPEAT_RATE_CNT) ?
                                   REPEAT_START_CNT : REPEAT_RATE_CNT;
  localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;

  localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CNT - 1);
  localparam logic [RepW-1:0] StartLast = RepW'(REPEAT_START_CNT - 1);
  localparam logic [RepW-1:0] RateLast  = RepW'(REPEAT_RATE_CNT - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDelay  = 2'd1;
  localparam logic [1:0] StRepeat = 2'd2;
  localparam logic [1:0] StLock   = 2'd3;

  // Bit 0 = inc key, bit 1 = dec key (matches dir encoding).
  logic [1:0] key_raw;
  logic [1:0] deb_n;

  assign key_raw = {key_dec_n, key_inc_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [1:0]     sync_q;
    logic [DbW-1:0] cnt_q;
    logic           deb_q;

    // Two-flop synchronizer followed by a run-length debouncer.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= 2'b11;
        cnt_q  <= '0;
        deb_q  <= 1'b1;
      end else begin
        sync_q <= {sync_q[0], key_raw[k]};
        if (sync_q[1] == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DbLast) begin
          deb_q <= sync_q[1];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign deb_n[k] = deb_q;
  end

  logic [1:0]      state_q, state_d;
  logic            dir_q, dir_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            inc_stb_q, inc_stb_d;
  logic            dec_stb_q, dec_stb_d;
  logic            busy_q, busy_d;

  logic inc_p, dec_p, held_p, other_p;
  logic [RepW-1:0] rep_last;

  assign inc_p    = ~deb_n[0];
  assign dec_p    = ~deb_n[1];
  assign held_p   = dir_q ? dec_p : inc_p;
  assign other_p  = dir_q ? inc_p : dec_p;
  assign rep_last = (state_q == StDelay) ? StartLast : RateLast;

  // Next-state, repeat timer and strobe decode.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rep_cnt_d = rep_cnt_q;
    inc_stb_d = 1'b0;
    dec_stb_d = 1'b0;
    if (!en) begin
      // Held keys must be released before they can strobe again.
      state_d = StLock;
    end else begin
      case (state_q)
        StIdle: begin
          if (inc_p && dec_p) begin
            state_d = StLock;
          end else if (inc_p || dec_p) begin
            inc_stb_d = inc_p;
            dec_stb_d = dec_p;
            dir_d     = dec_p;
            rep_cnt_d = '0;
            state_d   = StDelay;
          end
        end
        StDelay, StRepeat: begin
          // Release wins over a coincident timer expiry.
          if (!held_p) begin
            state_d = StIdle;
          end else if (other_p) begin
            state_d = StLock;
          end else if (rep_cnt_q == rep_last) begin
            inc_stb_d = ~dir_q;
            dec_stb_d = dir_q;
            rep_cnt_d = '0;
            state_d   = StRepeat;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        default: begin
          if (!inc_p && !dec_p) state_d = StIdle;
        end
      endcase
    end
    busy_d = (state_d != StIdle);
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dir_q     <= 1'b0;
      rep_cnt_q <= '0;
      inc_stb_q <= 1'b0;
      dec_stb_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      rep_cnt_q <= rep_cnt_d;
      inc_stb_q <= inc_stb_d;
      dec_stb_q <= dec_stb_d;
      busy_q    <= busy_d;
    end
  end

  assign inc_stb = inc_stb_q;
  assign dec_stb = dec_stb_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_param_key_repeater.sv
// Bench for param_key_repeater: directed hold/glitch/lock/enable/reset
// scenarios plus random key activity, all compared cycle by cycle against a
// behavioural model of the key semantics.
module tb_param_key_repeater;

  localparam int unsigned D  = 4;
  localparam int unsigned RS = 20;
  localparam int unsigned RR = 5;

  logic clk = 1'b0;
  logic rst_n, en, key_inc_n, key_dec_n;
  logic inc_stb, dec_stb, busy;

  param_key_repeater #(
    .DEBOUNCE_CNT     (D),
    .REPEAT_START_CNT (RS),
    .REPEAT_RATE_CNT  (RR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .key_inc_n (key_inc_n),
    .key_dec_n (key_dec_n),
    .inc_stb   (inc_stb),
    .dec_stb   (dec_stb),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int inc_log[$];
  int dec_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at t=%0t cyc=%0d: got %0d expected %0d", tag, $time, cyc, got, exp);
    end
  endtask

  // Model state: raw->sync delay line, debounced level with its run of
  // disagreeing samples, and the hold/lock behaviour of the keypad.
  int m_s1[2], m_s2[2], m_deb[2], m_run[2];
  int m_locked, m_held, m_age, m_period;
  int m_inc, m_dec, m_busy;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 1; m_s2[k] = 1; m_deb[k] = 1; m_run[k] = 0;
    end
    m_locked = 0; m_held = -1; m_age = 0; m_period = RS;
    m_inc = 0; m_dec = 0; m_busy = 0;
  endtask

  task automatic model_fire(input int key);
    if (key == 0) m_inc = 1;
    else m_dec = 1;
  endtask

  task automatic model_step();
    int pi, pd, hp, op;
    int raw[2];
    pi = (m_deb[0] == 0);
    pd = (m_deb[1] == 0);
    raw[0] = key_inc_n;
    raw[1] = key_dec_n;
    m_inc = 0;
    m_dec = 0;
    if (!en) begin
      m_locked = 1; m_held = -1;
    end else if (m_locked != 0) begin
      if (!pi && !pd) m_locked = 0;
    end else if (m_held < 0) begin
      if (pi && pd) m_locked = 1;
      else if (pi || pd) begin
        m_held = pd ? 1 : 0;
        model_fire(m_held);
        m_age = 0; m_period = RS;
      end
    end else begin
      hp = (m_held == 1) ? pd : pi;
      op = (m_held == 1) ? pi : pd;
      if (!hp) m_held = -1;
      else if (op) begin m_locked = 1; m_held = -1; end
      else if (m_age == m_period - 1) begin
        model_fire(m_held);
        m_age = 0; m_period = RR;
      end else m_age++;
    end
    m_busy = (m_locked != 0 || m_held >= 0) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      if (m_s2[k] == m_deb[k]) m_run[k] = 0;
      else begin
        m_run[k]++;
        if (m_run[k] == D) begin m_deb[k] = m_s2[k]; m_run[k] = 0; end
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = raw[k];
    end
  endtask

  // One clock: model advance at the edge, compare 1 time unit later, return
  // 2 units after the edge so the caller's input changes sit mid-cycle.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    cyc++;
    #1;
    check_eq("inc_stb", inc_stb, m_inc);
    check_eq("dec_stb", dec_stb, m_dec);
    check_eq("busy", busy, m_busy);
    check_eq("stb_exclusive", inc_stb & dec_stb, 0);
    if (inc_stb === 1'b1) inc_log.push_back(cyc);
    if (dec_stb === 1'b1) dec_log.push_back(cyc);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    cyc = 0;
    inc_log.delete();
    dec_log.delete();
  endtask

  // Asynchronous reset pulse spanning one edge; cycle count restarts at release.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_inc_stb", inc_stb, 0);
    check_eq("rst_dec_stb", dec_stb, 0);
    check_eq("rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
    model_reset();
    #2;

    // Inc held through reset release: strobes at 7, 27, 32, 37.
    key_inc_n = 1'b0;
    do_reset();
    run(40);
    check_eq("hold_nstb", inc_log.size(), 4);
    check_eq("hold_first", inc_log[0], 7);
    check_eq("hold_second", inc_log[1], 27);
    check_eq("hold_third", inc_log[2], 32);
    check_eq("hold_fourth", inc_log[3], 37);
    check_eq("hold_no_dec", dec_log.size(), 0);

    // Reset mid-repeat with key still held, then release timed so the
    // debounced release lands on the repeat expiry at cycle 37.
    do_reset();
    run(30);
    key_inc_n = 1'b1;
    run(15);
    check_eq("rel_nstb", inc_log.size(), 3);
    check_eq("rel_after_rst", inc_log[0], 7);
    check_eq("rel_last", inc_log[2], 32);
    check_eq("rel_busy", busy, 0);

    // Short dec glitch must not register.
    do_reset();
    run(10);
    key_dec_n = 1'b0;
    run(3);
    key_dec_n = 1'b1;
    run(15);
    check_eq("glitch_nstb", dec_log.size(), 0);
    check_eq("glitch_busy", busy, 0);

    // Inc held, dec joins at cycle 15 -> lock until both released.
    key_inc_n = 1'b0;
    do_reset();
    run(14);
    key_dec_n = 1'b0;
    run(26);
    check_eq("lock_inc_only", inc_log.size(), 1);
    check_eq("lock_no_dec", dec_log.size(), 0);
    check_eq("lock_busy", busy, 1);
    key_inc_n = 1'b1;
    key_dec_n = 1'b1;
    run(15);
    key_dec_n = 1'b0;
    clear_logs();
    run(12);
    check_eq("lock_redec_n", dec_log.size(), 1);
    check_eq("lock_redec_cyc", dec_log[0], 7);
    key_dec_n = 1'b1;
    run(15);

    // Enable dropped at cycle 20 and restored at 40 while inc held.
    key_inc_n = 1'b0;
    do_reset();
    run(19);
    en = 1'b0;
    run(20);
    en = 1'b1;
    run(41);
    check_eq("en_nstb", inc_log.size(), 1);
    key_inc_n = 1'b1;
    run(10);
    key_inc_n = 1'b0;
    clear_logs();
    run(10);
    check_eq("en_repress", inc_log[0], 7);
    key_inc_n = 1'b1;
    run(10);

    // Random key activity, enables and occasional resets.
    for (int s = 0; s < 70; s++) begin
      int dur;
      key_inc_n = ($urandom_range(0, 1) == 0);
      key_dec_n = ($urandom_range(0, 9) >= 3);
      en        = ($urandom_range(0, 9) != 0);
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 60);
      if ($urandom_range(0, 24) == 0) do_reset();
      run(dur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
